coso_harvest_controller: RTL and testbench

- Sequences the coherent sampler datapath once the RO-pair configuration controller reports a match.
- Snoops coherent sampler counter samples and discards a warm-up run after each new match.
- Packs the counter LSBs into raw entropy words and delivers them over a valid/ready handshake.
- Aborts and restarts on match loss or oscillator lock, and latches a sticky failure on noFound. Sits between the coherent sampler/matching controller pair and the post-processing or readout logic.

---
 rtl/coso_harvest_controller.sv | 188 ++++++++++++++++++
 tb/tb_coso_harvest_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coso_harvest_controller.sv
// Harvests coherent-sampler counter LSBs into raw entropy words once the RO-pair
// matching controller reports a good configuration; handles warm-up, aborts and failure.
module coso_harvest_controller #(
    parameter int CSCntLength   = 16,
    parameter int WordWidth     = 32,
    parameter int BitsPerSample = 1,
    parameter int WarmupLog     = 4,
    parameter int StatLength    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [CSCntLength-1:0] CSCnt,
    input  logic                   CSReq,
    input  logic                   matched,
    input  logic                   locked,
    input  logic                   noFound,
    output logic [WordWidth-1:0]   dataOut,
    output logic                   dataValid,
    input  logic                   dataReady,
    output logic                   harvesting,
    output logic                   failed,
    output logic [StatLength-1:0]  dropCnt,
    output logic [StatLength-1:0]  overrunCnt,
    output logic [2:0]             state_dbg_o
);

    localparam int SamplesPerWord = WordWidth / BitsPerSample;
    localparam int CntW           = $clog2(SamplesPerWord + 1);
    localparam int WarmW          = (WarmupLog > 0) ? WarmupLog : 1;
    localparam logic [WarmW-1:0] WarmLast = WarmW'((1 << WarmupLog) - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(SamplesPerWord - 1);

    // Debug encoding: 0 IDLE, 1 WAIT_MATCH, 2 WARMUP, 3 HARVEST, 4 OUTPUT, 5 FAILED.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_MATCH = 3'd1,
        ST_WARMUP     = 3'd2,
        ST_HARVEST    = 3'd3,
        ST_OUTPUT     = 3'd4,
        ST_FAILED     = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic                   csreq_q;
    logic [WarmW-1:0]       warm_q, warm_d;
    logic [CntW-1:0]        bitcnt_q, bitcnt_d;
    logic [WordWidth-1:0]   shift_q, shift_d;
    logic [WordWidth-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   harv_q, harv_d;
    logic                   failed_q, failed_d;
    logic [StatLength-1:0]  drop_q, drop_d;
    logic [StatLength-1:0]  over_q, over_d;

    logic                   sample_ev;
    logic                   abort;
    logic [WordWidth-1:0]   shifted;
    logic                   unused_cscnt;

    assign sample_ev    = CSReq & ~csreq_q;
    assign abort        = ~matched | locked;
    assign shifted      = (shift_q << BitsPerSample) | WordWidth'(CSCnt[BitsPerSample-1:0]);
    assign unused_cscnt = ^CSCnt;

    // Output handshake: dataOut/dataValid are held from the cycle dataValid rises
    // until the first cycle with dataValid & dataReady; the word transfers on that edge.
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        failed_d = failed_q;
        drop_d   = drop_q;
        over_d   = over_q;

        if (noFound && state_q != ST_IDLE) begin
            state_d  = ST_FAILED;
            failed_d = 1'b1;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_WAIT_MATCH;
                end
                ST_WAIT_MATCH: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (matched && !locked) begin
                        state_d = ST_WARMUP;
                        warm_d  = '0;
                    end
                end
                ST_WARMUP: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (abort) begin
                        state_d = ST_WAIT_MATCH;
                    end else if (sample_ev) begin
                        if (warm_q == WarmLast) begin
                            state_d  = ST_HARVEST;
                            shift_d  = '0;
                            bitcnt_d = '0;
                        end else begin
                            warm_d = warm_q + 1'b1;
                        end
                    end
                end
                ST_HARVEST: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (abort) begin
                        state_d = ST_WAIT_MATCH;
                        if (bitcnt_q != '0 && drop_q != '1) drop_d = drop_q + 1'b1;
                    end else if (sample_ev) begin
                        if (bitcnt_q == CntLast) begin
                            state_d  = ST_OUTPUT;
                            data_d   = shifted;
                            valid_d  = 1'b1;
                            shift_d  = '0;
                            bitcnt_d = '0;
                        end else begin
                            shift_d  = shifted;
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (sample_ev && over_q != '1) over_d = over_q + 1'b1;
                    if (valid_q && dataReady) begin
                        valid_d = 1'b0;
                        if (enable && matched && !locked) state_d = ST_HARVEST;
                        else if (enable)                  state_d = ST_WAIT_MATCH;
                        else                              state_d = ST_IDLE;
                    end
                end
                ST_FAILED: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        harv_d = (state_d == ST_HARVEST) || (state_d == ST_OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            csreq_q  <= 1'b0;
            warm_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            harv_q   <= 1'b0;
            failed_q <= 1'b0;
            drop_q   <= '0;
            over_q   <= '0;
        end else begin
            state_q  <= state_d;
            csreq_q  <= CSReq;
            warm_q   <= warm_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            harv_q   <= harv_d;
            failed_q <= failed_d;
            drop_q   <= drop_d;
            over_q   <= over_d;
        end
    end

    assign dataOut     = data_q;
    assign dataValid   = valid_q;
    assign harvesting  = harv_q;
    assign failed      = failed_q;
    assign dropCnt     = drop_q;
    assign overrunCnt  = over_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_coso_harvest_controller.sv
// Bench for coso_harvest_controller: directed scenarios plus a randomized run, all
// compared every cycle against a sample-queue reference model.
module tb_coso_harvest_controller;

    localparam int CW = 16;
    localparam int WW = 32;
    localparam int WARM_N = 16;
    localparam int SPW = 32;
    localparam int STAT_MAX = 255;

    localparam int S_IDLE = 0;
    localparam int S_WAIT = 1;
    localparam int S_WARM = 2;
    localparam int S_HARV = 3;
    localparam int S_OUT  = 4;
    localparam int S_FAIL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, enable, csreq, matched, locked, nofound, ready;
    logic [CW-1:0] cscnt;
    logic [WW-1:0] data;
    logic          valid, harv, failed;
    logic [7:0]    drop, over;
    logic [2:0]    state;

    logic          en_b, req_b, rdy_b;
    logic [CW-1:0] cnt_b;
    logic [WW-1:0] b_data;
    logic          b_valid, b_harv, b_failed;
    logic [7:0]    b_drop, b_over;
    logic [2:0]    b_state;

    coso_harvest_controller dut (
        .clk(clk), .rst(rst), .enable(enable), .CSCnt(cscnt), .CSReq(csreq),
        .matched(matched), .locked(locked), .noFound(nofound),
        .dataOut(data), .dataValid(valid), .dataReady(ready),
        .harvesting(harv), .failed(failed), .dropCnt(drop), .overrunCnt(over),
        .state_dbg_o(state)
    );

    coso_harvest_controller #(.BitsPerSample(4)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .CSCnt(cnt_b), .CSReq(req_b),
        .matched(1'b1), .locked(1'b0), .noFound(1'b0),
        .dataOut(b_data), .dataValid(b_valid), .dataReady(rdy_b),
        .harvesting(b_harv), .failed(b_failed), .dropCnt(b_drop), .overrunCnt(b_over),
        .state_dbg_o(b_state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a mode, a count of warm-up samples seen and a queue of harvested samples.
    int            m_mode, m_warm, m_drop, m_over;
    int            m_bits[$];
    logic          m_req, m_valid, m_failed;
    logic [WW-1:0] m_out;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] word_of_samples();
        logic [63:0] w = 0;
        foreach (m_bits[i]) w = (w << 1) | 64'(m_bits[i]);
        return w[WW-1:0];
    endfunction

    task automatic model_step();
        logic ev;
        ev = csreq && !m_req;
        if (rst) begin
            m_mode = S_IDLE; m_warm = 0; m_drop = 0; m_over = 0; m_bits.delete();
            m_req = 1'b0; m_valid = 1'b0; m_failed = 1'b0; m_out = '0;
            return;
        end
        m_req = csreq;
        if (nofound && m_mode != S_IDLE) begin
            m_mode = S_FAIL; m_failed = 1'b1; m_valid = 1'b0;
            return;
        end
        case (m_mode)
            S_IDLE: if (enable) m_mode = S_WAIT;
            S_WAIT: begin
                if (!enable) m_mode = S_IDLE;
                else if (matched && !locked) begin m_mode = S_WARM; m_warm = 0; end
            end
            S_WARM: begin
                if (!enable) m_mode = S_IDLE;
                else if (!matched || locked) m_mode = S_WAIT;
                else if (ev) begin
                    m_warm++;
                    if (m_warm == WARM_N) begin m_mode = S_HARV; m_bits.delete(); end
                end
            end
            S_HARV: begin
                if (!enable) begin m_mode = S_IDLE; m_bits.delete(); end
                else if (!matched || locked) begin
                    if (m_bits.size() > 0 && m_drop < STAT_MAX) m_drop++;
                    m_bits.delete();
                    m_mode = S_WAIT;
                end else if (ev) begin
                    m_bits.push_back(int'(cscnt[0]));
                    if (m_bits.size() == SPW) begin
                        m_out = word_of_samples();
                        m_bits.delete();
                        m_valid = 1'b1;
                        m_mode = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (ev && m_over < STAT_MAX) m_over++;
                if (ready) begin
                    m_valid = 1'b0;
                    m_bits.delete();
                    if (enable && matched && !locked) m_mode = S_HARV;
                    else if (enable) m_mode = S_WAIT;
                    else m_mode = S_IDLE;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check("state", 64'(state), 64'(m_mode));
        check("dataValid", 64'(valid), 64'(m_valid));
        check("dataOut", 64'(data), 64'(m_out));
        check("harvesting", 64'(harv), 64'(m_mode == S_HARV || m_mode == S_OUT));
        check("failed", 64'(failed), 64'(m_failed));
        check("dropCnt", 64'(drop), 64'(m_drop));
        check("overrunCnt", 64'(over), 64'(m_over));
    endtask

    // One clock: inputs already applied after a falling edge; compare at the next falling edge.
    task automatic cyc();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input logic [CW-1:0] v);
        cscnt = v; csreq = 1'b1; cyc();
        csreq = 1'b0; cyc();
    endtask

    task automatic pulse_b(input logic [CW-1:0] v);
        cnt_b = v; req_b = 1'b1; cyc();
        req_b = 1'b0; cyc();
    endtask

    task automatic rand_word_pulses(input int n);
        for (int i = 0; i < n; i++) pulse(16'($urandom));
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; csreq = 1'b0; matched = 1'b0; locked = 1'b0;
        nofound = 1'b0; ready = 1'b0; cscnt = '0;
        en_b = 1'b0; req_b = 1'b0; rdy_b = 1'b0; cnt_b = '0;
        cyc(); cyc();
        check("reset_dataOut", 64'(data), 64'h0);
        check("reset_overrun", 64'(over), 64'h0);
        rst = 1'b0;

        // noFound while idle must not fail the block
        nofound = 1'b1; cyc();
        check("idle_nofound_failed", 64'(failed), 64'h0);
        nofound = 1'b0; cyc();

        // 4-bit samples on the second instance: nibbles 1..8 form 0x12345678
        en_b = 1'b1; cyc(); cyc();
        for (int i = 0; i < WARM_N; i++) pulse_b(16'hFFFF);
        for (int k = 1; k <= 8; k++) pulse_b({12'($urandom), 4'(k)});
        check("b_valid", 64'(b_valid), 64'h1);
        check("b_dataOut", 64'(b_data), 64'h12345678);
        rdy_b = 1'b1; cyc();
        check("b_valid_after_accept", 64'(b_valid), 64'h0);
        en_b = 1'b0; cyc();

        // warm-up discard followed by alternating LSBs
        enable = 1'b1; matched = 1'b1; cyc(); cyc();
        for (int i = 0; i < WARM_N; i++) pulse(16'hFFFF);
        for (int i = 0; i < SPW - 1; i++) pulse((16'($urandom) & 16'hFFFE) | 16'(i % 2 == 0));
        cscnt = 16'($urandom) & 16'hFFFE; csreq = 1'b1; cyc();
        check("first_word_valid", 64'(valid), 64'h1);
        check("first_word_data", 64'(data), 64'hAAAAAAAA);
        csreq = 1'b0;

        // stalled consumer with three sample edges
        for (int i = 0; i < 50; i++) begin
            csreq = (i == 5 || i == 20 || i == 35);
            cyc();
        end
        check("stall_overrun", 64'(over), 64'd3);
        check("stall_data", 64'(data), 64'hAAAAAAAA);
        check("stall_valid", 64'(valid), 64'h1);
        ready = 1'b1; cyc();
        check("accept_valid", 64'(valid), 64'h0);
        check("accept_state", 64'(state), 64'(S_HARV));

        // abort after 10 bits, then full warm-up again
        rand_word_pulses(10);
        matched = 1'b0; cyc();
        check("abort_state", 64'(state), 64'(S_WAIT));
        check("abort_drop", 64'(drop), 64'd1);
        matched = 1'b1; cyc();
        for (int i = 0; i < WARM_N - 1; i++) pulse(16'hFFFF);
        check("rewarm_state", 64'(state), 64'(S_WARM));
        pulse(16'hFFFF);
        check("rewarm_done", 64'(state), 64'(S_HARV));

        // lock on the word-completing event aborts the word
        rand_word_pulses(SPW - 1);
        locked = 1'b1; csreq = 1'b1; cscnt = 16'($urandom); cyc();
        check("lock_boundary_valid", 64'(valid), 64'h0);
        check("lock_boundary_drop", 64'(drop), 64'd2);
        locked = 1'b0; csreq = 1'b0; cyc();

        // lock pulse during OUTPUT does not cancel the pending word
        ready = 1'b0;
        for (int i = 0; i < WARM_N; i++) pulse(16'hFFFF);
        rand_word_pulses(SPW);
        locked = 1'b1; cyc();
        check("lock_in_output_valid", 64'(valid), 64'h1);
        locked = 1'b0; ready = 1'b1; cyc();
        check("lock_in_output_accept", 64'(valid), 64'h0);

        // randomized run with rare disturbances
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 999) >= 1);
            matched = ($urandom_range(0, 999) >= 2);
            locked  = ($urandom_range(0, 999) < 2);
            csreq   = 1'($urandom_range(0, 1));
            ready   = ($urandom_range(0, 99) < 70);
            cscnt   = 16'($urandom);
            cyc();
        end

        // overrun saturation
        rst = 1'b1; enable = 1'b0; matched = 1'b0; locked = 1'b0; csreq = 1'b0; ready = 1'b0;
        cyc();
        rst = 1'b0; enable = 1'b1; matched = 1'b1; cyc(); cyc();
        for (int i = 0; i < WARM_N; i++) pulse(16'hFFFF);
        rand_word_pulses(SPW);
        for (int i = 0; i < 300; i++) pulse(16'($urandom));
        check("overrun_saturated", 64'(over), 64'hFF);
        check("overrun_valid", 64'(valid), 64'h1);

        // failure during a pending handshake
        nofound = 1'b1; ready = 1'b1; cyc();
        check("fail_valid", 64'(valid), 64'h0);
        check("fail_flag", 64'(failed), 64'h1);
        nofound = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ready = 1'($urandom_range(0, 1)); matched = 1'($urandom_range(0, 1));
            enable = 1'($urandom_range(0, 1)); csreq = 1'($urandom_range(0, 1));
            cyc();
        end
        check("fail_sticky", 64'(failed), 64'h1);
        check("fail_state", 64'(state), 64'(S_FAIL));
        rst = 1'b1; cyc();
        check("fail_cleared", 64'(failed), 64'h0);
        check("stats_cleared", 64'(over), 64'h0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
